// File: rtl/cbm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cbm_pkg
//  Description : Shared types, state encoding and helpers for the CBM issue
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package cbm_pkg;

    localparam int CBM_XLEN = 32;
    localparam int CBM_RD_W = 5;
    localparam int CBM_PC_W = $clog2(CBM_XLEN) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic [CBM_XLEN-1:0] a;
        logic [CBM_XLEN-1:0] b;
        logic [CBM_RD_W-1:0] rd;
    } cbm_req_t;

    localparam int CBM_REQ_W = $bits(cbm_req_t);

    function automatic logic [CBM_PC_W-1:0] popcount(input logic [CBM_XLEN-1:0] v);
        logic [CBM_PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < CBM_XLEN; i++) begin
            n = n + {{(CBM_PC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cbm_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cbm_req_fifo
//  Description : Synchronous request FIFO with occupancy count and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module cbm_req_fifo
    import cbm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [CBM_REQ_W-1:0] din_i,
    input  logic                 pop_i,
    output logic [CBM_REQ_W-1:0] dout_o,
    output logic [PTR_W:0]       count_o,
    output logic                 empty_o,
    output logic                 ready_o
);

    localparam logic [PTR_W:0] c_full = (PTR_W+1)'(DEPTH);

    logic [CBM_REQ_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic                 w_push;
    logic                 w_pop;

    assign ready_o = (r_count != c_full);
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign dout_o  = r_mem[r_rd_ptr];

    // A flush wins over both a push and a pop in the same cycle.
    assign w_push = push_i && ready_o && !flush_i;
    assign w_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/cbm_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cbm_issue_ctrl
//  Description : Initiator side of the column-bypass multiplier start/busy/
//                done interface. Optional macro CBM_SWAP_EN issues the
//                operand with fewer set bits as op_a.
//  Revision    : 1.0 - initial release
// ============================================================================
module cbm_issue_ctrl
    import cbm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [CBM_XLEN-1:0] req_a_i,
    input  logic [CBM_XLEN-1:0] req_b_i,
    input  logic [CBM_RD_W-1:0] req_rd_idx_i,
    input  logic                flush_i,
    output logic                mul_start_o,
    output logic [CBM_XLEN-1:0] mul_op_a_o,
    output logic [CBM_XLEN-1:0] mul_op_b_o,
    output logic [CBM_RD_W-1:0] mul_rd_idx_o,
    input  logic                mul_busy_i,
    input  logic                mul_done_i,
    input  logic [CBM_XLEN-1:0] mul_result_i,
    input  logic [CBM_RD_W-1:0] mul_rd_idx_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [CBM_XLEN-1:0] wb_value_o,
    output logic [CBM_RD_W-1:0] wb_rd_idx_o,
    output logic [PTR_W:0]      count_o,
    output logic                err_o
);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 w_launch;
    logic                 w_wb_valid;
    logic                 w_fifo_empty;
    logic                 w_fifo_ready;
    logic [CBM_REQ_W-1:0] w_head;
    cbm_req_t             w_head_req;
    logic [CBM_XLEN-1:0]  w_issue_a;
    logic [CBM_XLEN-1:0]  w_issue_b;
    logic                 r_dead;
    logic                 r_start;
    logic [CBM_XLEN-1:0]  r_op_a;
    logic [CBM_XLEN-1:0]  r_op_b;
    logic [CBM_RD_W-1:0]  r_op_rd;
    logic [CBM_XLEN-1:0]  r_wb_value;
    logic [CBM_RD_W-1:0]  r_wb_rd;
    logic                 r_err;

    cbm_req_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (req_valid_i),
        .din_i   ({req_a_i, req_b_i, req_rd_idx_i}),
        .pop_i   (w_launch),
        .dout_o  (w_head),
        .count_o (count_o),
        .empty_o (w_fifo_empty),
        .ready_o (w_fifo_ready)
    );

    assign w_head_req = w_head;

`ifdef CBM_SWAP_EN
    // CBM latency follows popcount(op_a); the low product bits are symmetric.
    logic w_swap;
    assign w_swap    = popcount(w_head_req.b) < popcount(w_head_req.a);
    assign w_issue_a = w_swap ? w_head_req.b : w_head_req.a;
    assign w_issue_b = w_swap ? w_head_req.a : w_head_req.b;
`else
    assign w_issue_a = w_head_req.a;
    assign w_issue_b = w_head_req.b;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (w_launch) w_next_state = ST_WAIT;
            ST_WAIT: if (mul_done_i) w_next_state = (r_dead || flush_i) ? ST_IDLE : ST_HOLD;
            ST_HOLD: begin
                if (flush_i)         w_next_state = ST_IDLE;
                else if (wb_ready_i) w_next_state = w_launch ? ST_WAIT : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Launching from HOLD on the acceptance cycle gives zero-bubble issue.
    always_comb begin
        w_launch   = 1'b0;
        w_wb_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: w_launch = !flush_i && !w_fifo_empty && !mul_busy_i;
            ST_HOLD: begin
                w_wb_valid = 1'b1;
                w_launch   = wb_ready_i && !flush_i && !w_fifo_empty && !mul_busy_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_start    <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_rd    <= '0;
            r_dead     <= 1'b0;
            r_wb_value <= '0;
            r_wb_rd    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_start <= w_launch;
            if (w_launch) begin
                r_op_a  <= w_issue_a;
                r_op_b  <= w_issue_b;
                r_op_rd <= w_head_req.rd;
            end
            if (w_launch)
                r_dead <= 1'b0;
            else if (r_state == ST_WAIT && flush_i)
                r_dead <= 1'b1;
            if (r_state == ST_WAIT && mul_done_i && !r_dead && !flush_i) begin
                r_wb_value <= mul_result_i;
                r_wb_rd    <= mul_rd_idx_i;
            end
            if (mul_done_i && r_state != ST_WAIT)
                r_err <= 1'b1;
        end
    end

    assign req_ready_o  = w_fifo_ready;
    assign mul_start_o  = r_start;
    assign mul_op_a_o   = r_op_a;
    assign mul_op_b_o   = r_op_b;
    assign mul_rd_idx_o = r_op_rd;
    assign wb_valid_o   = w_wb_valid;
    assign wb_value_o   = r_wb_value;
    assign wb_rd_idx_o  = r_wb_rd;
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: doc/cbm_issue_ctrl.md
Name: cbm_issue_ctrl

Overview:
- Initiator side of the column-bypass multiplier (CBM) start/busy/done interface.
- Accepts MUL requests from the execute stage through a valid/ready port and buffers them in a small FIFO.
- Issues one operation at a time to the CBM, captures the result and its destination register, and presents it to writeback through a valid/ready port.
- Only one operation is outstanding at the multiplier at any time.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- PTR_W, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  FIFO can accept a request
- req_a_i  in  32  multiplicand
- req_b_i  in  32  multiplier
- req_rd_idx_i  in  5  destination register
- flush_i  in  1  pipeline flush
- mul_start_o  out  1  one-cycle start pulse to the CBM
- mul_op_a_o  out  32  operand A to the CBM
- mul_op_b_o  out  32  operand B to the CBM
- mul_rd_idx_o  out  5  rd tag to the CBM
- mul_busy_i  in  1  CBM busy
- mul_done_i  in  1  CBM done pulse
- mul_result_i  in  32  CBM result (low 32 bits of the product)
- mul_rd_idx_i  in  5  rd tag returned by the CBM
- wb_valid_o  out  1  result valid
- wb_ready_i  in  1  writeback accepts the result
- wb_value_o  out  32  result value
- wb_rd_idx_o  out  5  result destination register
- count_o  out  PTR_W+1  FIFO occupancy
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i=1 at a clk_i edge): FIFO emptied, state IDLE.
  - All outputs 0 except req_ready_o=1.
  - err_o=0.
  - A reset during an in-flight operation abandons it; any later mul_done_i is ignored.
- FIFO:
  - Push when req_valid_i && req_ready_o.
  - req_ready_o = (count < DEPTH); this is registered state, with no combinational path from wb_ready_i.
  - Pop when the FSM launches.
  - A push and a pop in the same cycle leave the count unchanged. This is legal when full, but req_ready_o is still 0 in that cycle.
  - Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE: if the FIFO is not empty and mul_busy_i=0, drive mul_start_o=1 for exactly one cycle, pop the head, latch the operands and rd onto the mul_* outputs, and go to WAIT. mul_op_*/mul_rd_idx_o stay stable until the next launch.
  - WAIT: on mul_done_i, capture mul_result_i and mul_rd_idx_i into the holding register.
    - Normally go to HOLD.
    - If a flush marked the operation dead, go to IDLE.
    - mul_done_i may arrive in any cycle at or after 1 cycle past start; an op_a of 0 gives the minimum latency.
  - HOLD: wb_valid_o=1 with value and rd held stable.
    - On wb_ready_i go to IDLE.
    - If the FIFO is not empty and mul_busy_i=0, launch directly from HOLD in the same cycle as acceptance (zero-bubble back-to-back issue).
- Flush:
  - flush_i clears the FIFO. A push in the same cycle is dropped.
  - In WAIT, the in-flight result is marked dead and discarded on done.
  - In HOLD, wb_valid_o drops the next cycle.
  - flush_i has priority over a simultaneous launch; no launch occurs that cycle.
- Errors: mul_done_i outside WAIT sets err_o, and the done is ignored. err_o clears only on reset.
- Latency, request to wb_valid_o with an empty FIFO and an idle CBM: 1 (FIFO) + 1 (launch) + CBM latency + 1 (capture).

Optional Feature:
- CBM_SWAP_EN
- Defined:
  - At launch, if popcount(b) < popcount(a), drive mul_op_a_o=b and mul_op_b_o=a.
  - Because CBM latency tracks popcount(op_a), this minimises issue latency. The low-32-bit result is identical.
- Undefined: operands are passed unchanged and the popcount logic is not synthesised.

Decomposition:
- Shared package cbm_pkg holds:
  - CBM_XLEN=32, CBM_RD_W=5
  - the state encoding (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2)
  - a request struct {a, b, rd}
  - the popcount function used by CBM_SWAP_EN
- One natural sub-module: cbm_req_fifo, a synchronous FIFO (DEPTH, count, flush). The FSM stays in cbm_issue_ctrl.

Test Plan:
- a=7, b=9, rd=5, wb_ready_i=1 -> one mul_start_o pulse; wb_valid_o with value=63, rd=5; err_o=0.
- Three requests back-to-back: (3,4,rd1), (0,12345,rd2), (0xFFFF0000,3,rd3) -> results 12, 0, 0xFFFD0000 in order. No start is issued while mul_busy_i=1, and exactly one start per request.
- wb_ready_i held 0 for 10 cycles after the first result -> wb_value_o/wb_rd_idx_o stable; no second start; FIFO fills to 4 and req_ready_o=0; all results are delivered in order after release.
- flush_i asserted 2 cycles after launching (0x80000000,7,rd9) -> no wb_valid_o for that op; count_o=0; the next request (2,2,rd4) returns 4.
- mul_done_i forced high in IDLE -> err_o=1 and stays 1 until rst_i; rst_i asserted mid-WAIT -> all outputs at reset values.
- With CBM_SWAP_EN, request (0xFFFFFFFF,3) -> mul_op_a_o=3, mul_op_b_o=0xFFFFFFFF, result 0xFFFFFFFD. Without the macro, operands are unswapped and the result is the same.
